// File: rtl/ipg_msg_sched_pkg.sv
// Shared types and constants for the IPG message scheduler and its TX-side consumers.
package ipg_msg_sched_pkg;

  localparam int unsigned IPG_MSG_W   = 520;
  localparam int unsigned IPG_CHUNK_W = 64;
  localparam int unsigned IDX_W       = 4;
  localparam int unsigned DCNT_W      = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } sched_st_e;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/ipg_msg_sched_if.sv
// Requester-side and TX-side signalling of the IPG message scheduler.
interface ipg_msg_sched_if
  import ipg_msg_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned MSG_W   = IPG_MSG_W,
  parameter int unsigned CHUNK_W = IPG_CHUNK_W
) ();

  localparam int unsigned SRC_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*MSG_W-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   ipg_en;
  logic [CHUNK_W-1:0]     chunk_data;
  logic [IDX_W-1:0]       chunk_idx;
  logic                   chunk_last;
  logic                   chunk_take;
  logic [SRC_W-1:0]       msg_src;
  logic                   msg_done;
  logic                   msg_drop;
  logic [DCNT_W-1:0]      drop_cnt;

  modport master (
    output req_valid, req_data, chunk_take,
    input  req_ready, ipg_en, chunk_data, chunk_idx, chunk_last,
           msg_src, msg_done, msg_drop, drop_cnt
  );

  modport slave (
    input  req_valid, req_data, chunk_take,
    output req_ready, ipg_en, chunk_data, chunk_idx, chunk_last,
           msg_src, msg_done, msg_drop, drop_cnt
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  logic        found;
  int unsigned pos;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    pos     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = (32'(ptr_i) + i) % N;
      if (!found && req_i[IW'(pos)]) begin
        found              = 1'b1;
        grant_o[IW'(pos)]  = 1'b1;
        idx_o              = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/ipg_msg_sched.sv
// Arbitrates requester messages, holds one, and serves it MSB-first as chunks to the IPG TX engine,
// dropping it if the TX engine stops consuming for TIMEOUT cycles.
module ipg_msg_sched
  import ipg_msg_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned MSG_W   = IPG_MSG_W,
  parameter int unsigned CHUNK_W = IPG_CHUNK_W,
  parameter int unsigned TIMEOUT = 256
) (
  input logic            clk,
  input logic            rst,
  ipg_msg_sched_if.slave bus
);

  localparam int unsigned SRC_W  = $clog2(N_REQ);
  localparam int unsigned CHUNKS = ceil_div(MSG_W, CHUNK_W);
  localparam int unsigned PAD_W  = CHUNKS * CHUNK_W;
  localparam int unsigned WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT - 1);

  sched_st_e          state_q, state_d;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [CHUNK_W-1:0] chunk_q, chunk_d;
  logic               ipg_en_q, ipg_en_d;
  logic               done_q, done_d;
  logic               drop_q, drop_d;
  logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
  logic [N_REQ-1:0]   grant;
  logic [SRC_W-1:0]   gidx;
  logic [N_REQ-1:0]   req_ready_c;
  logic [MSG_W-1:0]   sel_msg;

  // Message is left-aligned in a whole number of chunks so the last chunk is zero-padded in its LSBs.
  function automatic logic [CHUNK_W-1:0] chunk_of(input logic [MSG_W-1:0] m,
                                                  input logic [IDX_W-1:0] k);
    logic [PAD_W-1:0] padded;
    padded                   = '0;
    padded[PAD_W-1 -: MSG_W] = m;
    padded                   = padded << (int'(k) * CHUNK_W);
    return padded[PAD_W-1 -: CHUNK_W];
  endfunction

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req_i  (bus.req_valid),
    .ptr_i  (rr_ptr_q),
    .grant_o(grant),
    .idx_o  (gidx)
  );

  assign sel_msg = MSG_W'(bus.req_data >> (int'(gidx) * MSG_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      msg_q    <= '0;
      src_q    <= '0;
      idx_q    <= '0;
      wd_q     <= '0;
      chunk_q  <= '0;
      ipg_en_q <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
      dcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      msg_q    <= msg_d;
      src_q    <= src_d;
      idx_q    <= idx_d;
      wd_q     <= wd_d;
      chunk_q  <= chunk_d;
      ipg_en_q <= ipg_en_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
      dcnt_q   <= dcnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    msg_d       = msg_q;
    src_d       = src_q;
    idx_d       = idx_q;
    wd_d        = wd_q;
    chunk_d     = chunk_q;
    ipg_en_d    = ipg_en_q;
    done_d      = 1'b0;
    drop_d      = 1'b0;
    dcnt_d      = dcnt_q;
    req_ready_c = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready_c = grant;
        if (|grant) begin
          msg_d    = sel_msg;
          src_d    = gidx;
          rr_ptr_d = (gidx == SRC_W'(N_REQ - 1)) ? '0 : gidx + SRC_W'(1);
          idx_d    = '0;
          wd_d     = '0;
          chunk_d  = chunk_of(sel_msg, '0);
          ipg_en_d = 1'b1;
          state_d  = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        // A take on the watchdog-expiry cycle is served rather than dropped.
        if (bus.chunk_take) begin
          if (idx_q == LAST_IDX) begin
            done_d   = 1'b1;
            ipg_en_d = 1'b0;
            idx_d    = '0;
            chunk_d  = '0;
            state_d  = ST_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            wd_d    = '0;
            chunk_d = chunk_of(msg_q, idx_q + IDX_W'(1));
          end
        end else if (TIMEOUT != 0 && wd_q == WD_MAX) begin
          drop_d   = 1'b1;
          dcnt_d   = (dcnt_q != '1) ? dcnt_q + DCNT_W'(1) : dcnt_q;
          ipg_en_d = 1'b0;
          idx_d    = '0;
          chunk_d  = '0;
          state_d  = ST_IDLE;
        end else if (TIMEOUT != 0) begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.ipg_en     = ipg_en_q;
  assign bus.chunk_data = chunk_q;
  assign bus.chunk_idx  = idx_q;
  assign bus.chunk_last = (idx_q == LAST_IDX);
  assign bus.msg_src    = src_q;
  assign bus.msg_done   = done_q;
  assign bus.msg_drop   = drop_q;
  assign bus.drop_cnt   = dcnt_q;

endmodule
